// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths and ld_op encodings shared by mem_stage and mem_ld_align
package mem_stage_pkg;
  localparam int ES_TO_MS_BUS_WD = 130;
  localparam int MS_TO_WS_BUS_WD = 124;
  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;
endpackage

// File: rtl/mem_ld_align.sv
// mem_ld_align: (ld_op, addr_lo, rdata, gr_strb) -> (strb, result) load extract/align; lwl/lwr need MS_UNALIGNED_LD_EN, else act as lw
module mem_ld_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  ld_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [3:0]  gr_strb,
  output logic [3:0]  strb,
  output logic [31:0] result
);
  logic [31:0] shr, lwx;
  logic [15:0] half;
  logic [3:0]  lwx_strb;
  assign shr  = rdata >> {addr_lo, 3'b000};
  assign half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
`ifdef MS_UNALIGNED_LD_EN
  assign lwx      = ld_op == LD_LWL ? rdata << {~addr_lo, 3'b000} : shr;
  assign lwx_strb = ld_op == LD_LWL ? 4'b1111 << ~addr_lo : 4'b1111 >> addr_lo;
`else
  assign lwx      = rdata;
  assign lwx_strb = 4'b1111;
`endif
  assign strb   = ld_op >= LD_LWL ? lwx_strb : gr_strb;
  assign result = ld_op == LD_LB  ? {{24{shr[7]}}, shr[7:0]} :
                  ld_op == LD_LBU ? {24'd0, shr[7:0]} :
                  ld_op == LD_LH  ? {{16{half[15]}}, half} :
                  ld_op == LD_LHU ? {16'd0, half} :
                  ld_op >= LD_LWL ? lwx : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage (clk, reset, ES/WS handshakes, data_sram response, ws_flush discard counter, hazard outputs); MS_UNALIGNED_LD_EN enables lwl/lwr
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       es_req_fire,
  input  logic                       ws_flush,
  output logic [4:0]                 ms_rf_dest,
  output logic                       ms_inst_mfc0_o,
  output logic                       ms_ex_o
);
  logic                       ms_valid, data_got, mem_req, resp_ok, ms_ready_go, is_load;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic [31:0]                rdata_buf, ld_rdata, ld_result;
  logic [3:0]                 ld_strb;
  logic [1:0]                 discard_cnt, flush_inc;
  assign mem_req        = ms_bus[124];
  assign is_load        = ms_bus[129:127] != LD_NONE;
  assign resp_ok        = data_sram_data_ok && discard_cnt == 2'd0;
  assign ms_ready_go    = !mem_req || data_got || resp_ok;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush;
  assign ld_rdata       = data_got ? rdata_buf : data_sram_rdata;
  assign flush_inc      = ws_flush ? 2'(ms_valid && mem_req && !data_got && !resp_ok) + 2'(es_req_fire) : 2'd0;
  assign ms_rf_dest     = ms_valid ? ms_bus[68:64] : 5'd0;
  assign ms_inst_mfc0_o = ms_valid && ms_bus[74];
  assign ms_ex_o        = ms_valid && (ms_bus[78] || ms_bus[76]);
  assign ms_to_ws_bus   = {ms_bus[123:73], is_load ? ld_strb : ms_bus[72:69], ms_bus[68:64],
                           is_load ? ld_result : ms_bus[63:32], ms_bus[31:0]};
  mem_ld_align u_align (
    .ld_op   (ms_bus[129:127]),
    .addr_lo (ms_bus[126:125]),
    .rdata   (ld_rdata),
    .gr_strb (ms_bus[72:69]),
    .strb    (ld_strb),
    .result  (ld_result)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      data_got    <= 1'b0;
      discard_cnt <= 2'd0;
      ms_bus      <= '0;
      rdata_buf   <= 32'd0;
    end else begin
      ms_valid    <= ws_flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
      data_got    <= (ws_flush || (ms_ready_go && ws_allowin)) ? 1'b0 :
                     (ms_valid && mem_req && resp_ok) ? 1'b1 : data_got;
      discard_cnt <= discard_cnt - 2'(data_sram_data_ok && discard_cnt != 2'd0) + flush_inc;
      if (ms_allowin && es_to_ms_valid && !ws_flush) ms_bus <= es_to_ms_bus;
      if (ms_valid && mem_req && !data_got && resp_ok) rdata_buf <= data_sram_rdata;
    end
  end
endmodule
